// File: rtl/store_result_checker.sv
// Sticky pass/fail/timeout monitor for the core's data-memory store bus.
// All verdicts and counters are registered; outputs decode only flop state.
module store_result_checker #(
  parameter logic [31:0] PASS_ADDR      = 32'd0,
  parameter logic [31:0] PASS_DATA      = 32'd5040,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [15:0]      store_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  // state   | meaning
  // S_RUN   | program running, watching stores and cycle budget
  // S_PASS  | signature store seen
  // S_FAIL  | store to a non-signature address seen
  // S_TMO   | cycle budget exhausted without a verdict
  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  // A budget larger than the counter can express would never be reached.
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0) &&
                          ((CNT_W >= 32) || (64'(TIMEOUT_CYCLES) <= (64'd1 << CNT_W)));
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [15:0]      st_q, st_d;
  logic [31:0]      faddr_q, faddr_d;
  logic [31:0]      fdata_q, fdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cyc_q   <= '0;
      st_q    <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    st_d    = st_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (state_q == S_RUN) begin
      cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
      if (memwrite) begin
        st_d = (&st_q) ? st_q : st_q + 16'd1;
        if (dataadr == PASS_ADDR) begin
          if (writedata == PASS_DATA) state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          faddr_d = dataadr;
          fdata_d = writedata;
        end
      end
      // Store verdict has priority over the timeout on the same edge.
      if (TMO_EN && (state_d == S_RUN) && (cyc_q == TMO_LAST)) state_d = S_TMO;
    end
  end

  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign timeout     = (state_q == S_TMO);
  assign done        = (state_q != S_RUN);
  assign cycle_count = cyc_q;
  assign store_count = st_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;

endmodule

// File: tb/tb_store_result_checker.sv
// Directed bench: default instance, a short-timeout instance and a narrow,
// timeout-disabled instance share one stimulus bus.
module tb_store_result_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic        a_done, a_pass, a_fail, a_tmo;
  logic [31:0] a_cyc;
  logic [15:0] a_st;
  logic [31:0] a_faddr, a_fdata;

  logic        b_done, b_pass, b_fail, b_tmo;
  logic [31:0] b_cyc;
  logic [15:0] b_st;
  logic [31:0] b_faddr, b_fdata;

  logic        c_done, c_pass, c_fail, c_tmo;
  logic [3:0]  c_cyc;
  logic [15:0] c_st;
  logic [31:0] c_faddr, c_fdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  store_result_checker u_a (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tmo), .cycle_count(a_cyc),
    .store_count(a_st), .fail_addr(a_faddr), .fail_data(a_fdata));

  store_result_checker #(.TIMEOUT_CYCLES(20)) u_b (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tmo), .cycle_count(b_cyc),
    .store_count(b_st), .fail_addr(b_faddr), .fail_data(b_fdata));

  store_result_checker #(.TIMEOUT_CYCLES(0), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(c_done), .pass(c_pass), .fail(c_fail), .timeout(c_tmo), .cycle_count(c_cyc),
    .store_count(c_st), .fail_addr(c_faddr), .fail_data(c_fdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    memwrite = 1'b1; dataadr = adr; writedata = dat;
    tick();
    memwrite = 1'b0; dataadr = '0; writedata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({a_done, a_pass, a_fail, a_tmo} !== 4'b0) $display("FAIL reset_flags got=%b want=0000", {a_done, a_pass, a_fail, a_tmo}); else passed++;
    total++; if (a_cyc !== 32'd0) $display("FAIL reset_cycle_count got=%0d want=0", a_cyc); else passed++;
    total++; if (a_st !== 16'd0) $display("FAIL reset_store_count got=%0d want=0", a_st); else passed++;
    total++; if ({a_faddr, a_fdata} !== 64'd0) $display("FAIL reset_capture got=%h want=0", {a_faddr, a_fdata}); else passed++;
  endtask

  task automatic test_pass();
    do_reset();
    idle(9);
    total++; if (a_done !== 1'b0 || a_cyc !== 32'd9) $display("FAIL pass_pre done=%b cyc=%0d want done=0 cyc=9", a_done, a_cyc); else passed++;
    store(32'd0, 32'd5040);
    total++; if ({a_done, a_pass, a_fail, a_tmo} !== 4'b1100) $display("FAIL pass_flags got=%b want=1100", {a_done, a_pass, a_fail, a_tmo}); else passed++;
    total++; if (a_st !== 16'd1 || a_cyc !== 32'd10) $display("FAIL pass_counts st=%0d cyc=%0d want st=1 cyc=10", a_st, a_cyc); else passed++;
    store(32'd0, 32'd5040);
    idle(3);
    total++; if (a_st !== 16'd1 || a_cyc !== 32'd10 || a_pass !== 1'b1) $display("FAIL pass_frozen st=%0d cyc=%0d pass=%b want 1 10 1", a_st, a_cyc, a_pass); else passed++;
  endtask

  task automatic test_intermediate();
    do_reset();
    store(32'd0, 32'd7);
    total++; if (a_done !== 1'b0 || a_st !== 16'd1) $display("FAIL inter_first done=%b st=%0d want 0 1", a_done, a_st); else passed++;
    store(32'd0, 32'd12);
    total++; if (a_done !== 1'b0 || a_st !== 16'd2) $display("FAIL inter_second done=%b st=%0d want 0 2", a_done, a_st); else passed++;
    store(32'd0, 32'd5040);
    total++; if (a_pass !== 1'b1 || a_fail !== 1'b0 || a_st !== 16'd3) $display("FAIL inter_pass pass=%b fail=%b st=%0d want 1 0 3", a_pass, a_fail, a_st); else passed++;
  endtask

  task automatic test_fail();
    do_reset();
    store(32'd84, 32'd7);
    total++; if ({a_done, a_pass, a_fail, a_tmo} !== 4'b1010) $display("FAIL fail_flags got=%b want=1010", {a_done, a_pass, a_fail, a_tmo}); else passed++;
    total++; if (a_faddr !== 32'd84 || a_fdata !== 32'd7) $display("FAIL fail_capture addr=%0d data=%0d want 84 7", a_faddr, a_fdata); else passed++;
    store(32'd0, 32'd5040);
    total++; if (a_pass !== 1'b0 || a_fail !== 1'b1 || a_st !== 16'd1) $display("FAIL fail_sticky pass=%b fail=%b st=%0d want 0 1 1", a_pass, a_fail, a_st); else passed++;
    store(32'd96, 32'd3);
    total++; if (a_faddr !== 32'd84 || a_fdata !== 32'd7) $display("FAIL fail_frozen addr=%0d data=%0d want 84 7", a_faddr, a_fdata); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    idle(19);
    total++; if (b_tmo !== 1'b0 || b_cyc !== 32'd19) $display("FAIL tmo_pre tmo=%b cyc=%0d want 0 19", b_tmo, b_cyc); else passed++;
    tick();
    total++; if ({b_done, b_pass, b_fail, b_tmo} !== 4'b1001 || b_cyc !== 32'd20) $display("FAIL tmo_hit flags=%b cyc=%0d want 1001 20", {b_done, b_pass, b_fail, b_tmo}, b_cyc); else passed++;
    store(32'd0, 32'd5040);
    idle(4);
    total++; if (b_cyc !== 32'd20 || b_pass !== 1'b0 || b_st !== 16'd0) $display("FAIL tmo_frozen cyc=%0d pass=%b st=%0d want 20 0 0", b_cyc, b_pass, b_st); else passed++;
  endtask

  task automatic test_timeout_tie();
    do_reset();
    idle(19);
    store(32'd0, 32'd5040);
    total++; if ({b_done, b_pass, b_fail, b_tmo} !== 4'b1100) $display("FAIL tie_flags got=%b want=1100", {b_done, b_pass, b_fail, b_tmo}); else passed++;
    total++; if (b_cyc !== 32'd20 || b_st !== 16'd1) $display("FAIL tie_counts cyc=%0d st=%0d want 20 1", b_cyc, b_st); else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    store(32'd84, 32'd7);
    total++; if (a_fail !== 1'b1) $display("FAIL mid_reach_fail got=%b want=1", a_fail); else passed++;
    reset = 1'b1; memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd9;
    tick();
    total++; if ({a_done, a_fail, a_faddr, a_fdata, a_st, a_cyc} !== '0) $display("FAIL mid_reset_clear done=%b fail=%b addr=%0d st=%0d cyc=%0d want all 0", a_done, a_fail, a_faddr, a_st, a_cyc); else passed++;
    reset = 1'b0;
    store(32'd0, 32'd5040);
    total++; if (a_pass !== 1'b1 || a_fail !== 1'b0 || a_st !== 16'd1 || a_faddr !== 32'd0) $display("FAIL mid_after pass=%b fail=%b st=%0d addr=%0d want 1 0 1 0", a_pass, a_fail, a_st, a_faddr); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    memwrite = 1'b1; dataadr = 32'd0; writedata = 32'd1;
    idle(65540);
    memwrite = 1'b0;
    total++; if (c_st !== 16'hFFFF) $display("FAIL sat_store_count got=%h want=ffff", c_st); else passed++;
    total++; if (c_cyc !== 4'hF || c_done !== 1'b0) $display("FAIL sat_cycle_count cyc=%h done=%b want f 0", c_cyc, c_done); else passed++;
    total++; if (a_done !== 1'b0 || a_cyc !== 32'd65540) $display("FAIL sat_wide_count done=%b cyc=%0d want 0 65540", a_done, a_cyc); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_intermediate();
    test_fail();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_run();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
